icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 13 +
 rtl/icache_ram.sv | 53 +++++
 rtl/icache.sv | 134 +++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned LINES_DEFAULT = 64;
    localparam int unsigned WORDS_DEFAULT = 4;
    localparam int unsigned XLEN          = 32;

    typedef enum logic {
        IDLE,
        REFILL
    } icache_state_t;

endpackage

// File: rtl/icache_ram.sv
// Tag, valid and data storage for the instruction cache.
// Asynchronous read, synchronous write; only the valid bits are reset.
module icache_ram
    import icache_pkg::*;
#(
    parameter int unsigned LINES = LINES_DEFAULT,
    parameter int unsigned WORDS = WORDS_DEFAULT,
    parameter int unsigned TAG_W = 22
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(LINES)-1:0]   rd_index,
    input  logic [$clog2(WORDS)-1:0]   rd_offset,
    output logic                       rd_valid_c,
    output logic [TAG_W-1:0]           rd_tag_c,
    output logic [XLEN-1:0]            rd_word_c,
    input  logic                       word_we,
    input  logic [$clog2(LINES)-1:0]   wr_index,
    input  logic [$clog2(WORDS)-1:0]   wr_offset,
    input  logic [XLEN-1:0]            wr_word,
    input  logic                       tag_we,
    input  logic [TAG_W-1:0]           wr_tag
);

    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [XLEN-1:0]  data_mem [LINES*WORDS];
    logic [LINES-1:0] valid;

    assign rd_valid_c = valid[rd_index];
    assign rd_tag_c   = tag_mem[rd_index];
    assign rd_word_c  = data_mem[{rd_index, rd_offset}];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_mem[{wr_index, wr_offset}] <= wr_word;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped, zero-latency-hit instruction cache with word-by-word refill.
// Define ICACHE_PERF_EN to add saturating hit_count / miss_count outputs.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned LINES = LINES_DEFAULT,
    parameter int unsigned WORDS = WORDS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  imem_data,
    output logic             imem_stall,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [XLEN-1:0]  hit_count,
    output logic [XLEN-1:0]  miss_count
`endif
);

    localparam int unsigned OFF_W  = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = XLEN - 2 - OFF_W - IDX_W;
    localparam int unsigned LINE_W = TAG_W + IDX_W;

    icache_state_t     state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              word_we, tag_we;

    logic [OFF_W-1:0]  offset;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic              rd_valid_c;
    logic [TAG_W-1:0]  rd_tag_c;
    logic              hit_c;
    logic              unused_addr_bits;

    assign offset           = imem_addr[OFF_W+1:2];
    assign index            = imem_addr[OFF_W+2 +: IDX_W];
    assign tag              = imem_addr[XLEN-1 -: TAG_W];
    assign unused_addr_bits = ^imem_addr[1:0];

    icache_ram #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (index),
        .rd_offset  (offset),
        .rd_valid_c (rd_valid_c),
        .rd_tag_c   (rd_tag_c),
        .rd_word_c  (imem_data),
        .word_we    (word_we),
        .wr_index   (line_q[IDX_W-1:0]),
        .wr_offset  (cnt_q),
        .wr_word    (mem_rdata),
        .tag_we     (tag_we),
        .wr_tag     (line_q[LINE_W-1 -: TAG_W])
    );

    assign hit_c    = rd_valid_c && (rd_tag_c == tag);
    assign mem_addr = {line_q, cnt_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Line base only matters while refilling, so it needs no reset.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        word_we    = 1'b0;
        tag_we     = 1'b0;
        mem_req    = 1'b0;
        imem_stall = 1'b1;
        case (state_q)
            IDLE: begin
                imem_stall = !hit_c;
                if (!hit_c) begin
                    line_d  = imem_addr[XLEN-1 -: LINE_W];
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    word_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    // Last beat commits the tag/valid; cnt wraps to zero naturally.
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        tag_we  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == IDLE) begin
            if (hit_c && (hit_count != '1)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (!hit_c && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
